// File: rtl/gpiotest_main_pinwalk.sv
// Board GPIO connectivity exerciser: walking-one then walking-zero across 32 header pins.
// Build option: define OSC_EN to drop the gpio_20 port (pin reserved for the oscillator path).
module gpiotest_main_pinwalk #(
    parameter int unsigned TICK_CYCLES = 12_000
) (
    input  logic clk,
    input  logic reset,
    output logic gpio_23,
    output logic gpio_25,
    output logic gpio_26,
    output logic gpio_27,
    output logic gpio_32,
    output logic gpio_35,
    output logic gpio_31,
    output logic gpio_37,
    output logic gpio_34,
    output logic gpio_43,
    output logic gpio_36,
    output logic gpio_42,
    output logic gpio_38,
    output logic gpio_28,
`ifndef OSC_EN
    output logic gpio_20,
`endif
    output logic gpio_10,
    output logic gpio_12,
    output logic gpio_21,
    output logic gpio_13,
    output logic gpio_19,
    output logic gpio_18,
    output logic gpio_11,
    output logic gpio_9,
    output logic gpio_6,
    output logic gpio_44,
    output logic gpio_4,
    output logic gpio_3,
    output logic gpio_48,
    output logic gpio_45,
    output logic gpio_47,
    output logic gpio_46,
    output logic gpio_2
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned SEQ_W = 6;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] tick_cnt;
    logic [SEQ_W-1:0] seq;
    logic             tick;

    assign tick = (tick_cnt == TICK_LAST);

    // Pattern bit for one pin index: selected pin inverted against the rest, polarity from seq[5].
    function automatic logic pat_bit(input logic [SEQ_W-1:0] s, input logic [4:0] idx);
        return (s[4:0] == idx) ^ s[5];
    endfunction

    // Prescaler and step counter
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            seq      <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            if (tick) begin
                seq <= seq + SEQ_W'(1);
            end
        end
    end

    // Registered pin decode; outputs lag seq by one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_23 <= 1'b0;
            gpio_25 <= 1'b0;
            gpio_26 <= 1'b0;
            gpio_27 <= 1'b0;
            gpio_32 <= 1'b0;
            gpio_35 <= 1'b0;
            gpio_31 <= 1'b0;
            gpio_37 <= 1'b0;
            gpio_34 <= 1'b0;
            gpio_43 <= 1'b0;
            gpio_36 <= 1'b0;
            gpio_42 <= 1'b0;
            gpio_38 <= 1'b0;
            gpio_28 <= 1'b0;
`ifndef OSC_EN
            gpio_20 <= 1'b0;
`endif
            gpio_10 <= 1'b0;
            gpio_12 <= 1'b0;
            gpio_21 <= 1'b0;
            gpio_13 <= 1'b0;
            gpio_19 <= 1'b0;
            gpio_18 <= 1'b0;
            gpio_11 <= 1'b0;
            gpio_9  <= 1'b0;
            gpio_6  <= 1'b0;
            gpio_44 <= 1'b0;
            gpio_4  <= 1'b0;
            gpio_3  <= 1'b0;
            gpio_48 <= 1'b0;
            gpio_45 <= 1'b0;
            gpio_47 <= 1'b0;
            gpio_46 <= 1'b0;
            gpio_2  <= 1'b0;
        end else begin
            gpio_23 <= pat_bit(seq, 5'd0);
            gpio_25 <= pat_bit(seq, 5'd1);
            gpio_26 <= pat_bit(seq, 5'd2);
            gpio_27 <= pat_bit(seq, 5'd3);
            gpio_32 <= pat_bit(seq, 5'd4);
            gpio_35 <= pat_bit(seq, 5'd5);
            gpio_31 <= pat_bit(seq, 5'd6);
            gpio_37 <= pat_bit(seq, 5'd7);
            gpio_34 <= pat_bit(seq, 5'd8);
            gpio_43 <= pat_bit(seq, 5'd9);
            gpio_36 <= pat_bit(seq, 5'd10);
            gpio_42 <= pat_bit(seq, 5'd11);
            gpio_38 <= pat_bit(seq, 5'd12);
            gpio_28 <= pat_bit(seq, 5'd13);
`ifndef OSC_EN
            gpio_20 <= pat_bit(seq, 5'd14);
`endif
            gpio_10 <= pat_bit(seq, 5'd15);
            gpio_12 <= pat_bit(seq, 5'd16);
            gpio_21 <= pat_bit(seq, 5'd17);
            gpio_13 <= pat_bit(seq, 5'd18);
            gpio_19 <= pat_bit(seq, 5'd19);
            gpio_18 <= pat_bit(seq, 5'd20);
            gpio_11 <= pat_bit(seq, 5'd21);
            gpio_9  <= pat_bit(seq, 5'd22);
            gpio_6  <= pat_bit(seq, 5'd23);
            gpio_44 <= pat_bit(seq, 5'd24);
            gpio_4  <= pat_bit(seq, 5'd25);
            gpio_3  <= pat_bit(seq, 5'd26);
            gpio_48 <= pat_bit(seq, 5'd27);
            gpio_45 <= pat_bit(seq, 5'd28);
            gpio_47 <= pat_bit(seq, 5'd29);
            gpio_46 <= pat_bit(seq, 5'd30);
            gpio_2  <= pat_bit(seq, 5'd31);
        end
    end

endmodule

// File: tb/tb_gpiotest_main_pinwalk.sv
// Bench for gpiotest_main_pinwalk: fixed vector table, reset corner sequences, random resets vs edge-count model.
module tb_gpiotest_main_pinwalk;

    localparam int TC = 4;

    logic clk;
    logic reset;
    logic [31:0] p;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // edges since reset release (0 while in reset)

    gpiotest_main_pinwalk #(.TICK_CYCLES(TC)) dut (
        .clk     (clk),
        .reset   (reset),
        .gpio_23 (p[0]),
        .gpio_25 (p[1]),
        .gpio_26 (p[2]),
        .gpio_27 (p[3]),
        .gpio_32 (p[4]),
        .gpio_35 (p[5]),
        .gpio_31 (p[6]),
        .gpio_37 (p[7]),
        .gpio_34 (p[8]),
        .gpio_43 (p[9]),
        .gpio_36 (p[10]),
        .gpio_42 (p[11]),
        .gpio_38 (p[12]),
        .gpio_28 (p[13]),
`ifndef OSC_EN
        .gpio_20 (p[14]),
`endif
        .gpio_10 (p[15]),
        .gpio_12 (p[16]),
        .gpio_21 (p[17]),
        .gpio_13 (p[18]),
        .gpio_19 (p[19]),
        .gpio_18 (p[20]),
        .gpio_11 (p[21]),
        .gpio_9  (p[22]),
        .gpio_6  (p[23]),
        .gpio_44 (p[24]),
        .gpio_4  (p[25]),
        .gpio_3  (p[26]),
        .gpio_48 (p[27]),
        .gpio_45 (p[28]),
        .gpio_47 (p[29]),
        .gpio_46 (p[30]),
        .gpio_2  (p[31])
    );

`ifdef OSC_EN
    assign p[14] = 1'b0;
    localparam logic [31:0] PMASK = 32'hFFFF_BFFF;
`else
    localparam logic [31:0] PMASK = 32'hFFFF_FFFF;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          edge_k;
        int          exp_seq;
        logic [31:0] exp_pins;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] decode(input int s);
        logic [31:0] v;
        v = 32'h1 << (s % 32);
        if ((s % 64) >= 32) v = ~v;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (k=%0d)", nm, act, exp, k);
        end
    endtask

    task automatic check_model();
        logic [31:0] ep;
        chk("seq", 32'(dut.seq), 32'((k / TC) % 64));
        chk("tick_cnt", 32'(dut.tick_cnt), 32'(k % TC));
        ep = (k == 0) ? 32'h0 : decode((k - 1) / TC);
        chk("pins", p & PMASK, ep & PMASK);
        if (k >= 1 && (((k - 1) / TC) % 64) < 32)
            chk("onehot", 32'($countones(p & PMASK)), ((((k - 1) / TC) % 32) == 14 && PMASK[14] == 1'b0) ? 32'd0 : 32'd1);
    endtask

    task automatic step(input logic r);
        reset = r;
        @(posedge clk);
        if (r) k = 0;
        else   k++;
        #1;
        check_model();
    endtask

    initial begin
        tbl[0] = '{1,   0,  32'h0000_0001};
        tbl[1] = '{4,   1,  32'h0000_0001};
        tbl[2] = '{5,   1,  32'h0000_0002};
        tbl[3] = '{8,   2,  32'h0000_0002};
        tbl[4] = '{57,  14, 32'h0000_4000};
        tbl[5] = '{125, 31, 32'h8000_0000};
        tbl[6] = '{129, 32, 32'hFFFF_FFFE};
        tbl[7] = '{253, 63, 32'h7FFF_FFFF};
        tbl[8] = '{256, 0,  32'h7FFF_FFFF};
        tbl[9] = '{257, 0,  32'h0000_0001};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk("rst_pins", p & PMASK, 32'h0);
        end

        // Fixed checkpoints across the sweep and the 63->0 wrap
        for (int e = 0; e < 10; e++) begin
            while (k < tbl[e].edge_k) step(1'b0);
            chk("tbl_seq", 32'(dut.seq), 32'(tbl[e].exp_seq));
            chk("tbl_pins", p & PMASK, tbl[e].exp_pins & PMASK);
        end

        // Mid-sweep reset at seq=40
        for (int i = 0; i < 64 * TC * 2; i++) begin
            if (((k / TC) % 64) == 40) break;
            step(1'b0);
        end
        chk("reach_seq40", 32'(dut.seq), 32'd40);
        step(1'b1);
        chk("midrst_seq", 32'(dut.seq), 32'd0);
        chk("midrst_cnt", 32'(dut.tick_cnt), 32'd0);
        chk("midrst_pins", p & PMASK, 32'h0);
        step(1'b0);
        chk("restart_pins", p & PMASK, 32'h0000_0001);

        // Random reset pulses, model checked every cycle
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
